multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Control FSM that sequences a multi-cycle RV32I datapath over one shared instr/data memory port.
//  Decodes opcode/funct from the instruction register; drives the mux selects, ALU op and write enables.
//  Waits on a memory ready handshake; traps on illegal encodings or memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  255  max wait cycles per memory access before TRAP; 0 disables timeout
// PORTS
//  clk         in   1  clock
//  rst         in   1  reset, synchronous, active-high
//  opcode      in   7  IR[6:0]; valid from DECODE onward
//  funct_3     in   3  IR[14:12]
//  funct_7_5   in   1  IR[30]
//  zero        in   1  ALU zero flag, same cycle
//  mem_ready   in   1  memory access completes this cycle
//  mem_req     out  1  memory access request
//  mem_write   out  1  store strobe; valid with mem_req
//  adr_src     out  1  memory address: 0=PC, 1=ALUOut
//  ir_write    out  1  load IR and OldPC
//  pc_write    out  1  load PC from result
//  reg_write   out  1  register file write enable
//  alu_src_a   out  2  00=PC, 01=OldPC, 10=rd1
//  alu_src_b   out  2  00=rd2, 01=ImmExt, 10=const 4
//  result_src  out  2  00=ALUOut reg, 01=Data reg, 10=ALU result
//  alu_ctrl    out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  imm_src     out  2  I=00, S=01, B=10, J=11; from opcode, 00 otherwise
//  trap        out  1  sticky error flag; high while state==TRAP
//  state       out  4  current state code (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEM_ADR=2 MEM_READ=3 MEM_WB=4 MEM_WRITE=5 EXEC_R=6 EXEC_I=7
//    ALU_WB=8 JAL=9 BRANCH=10 TRAP=15. Outputs are Moore, decoded from the state register.
//  Every output not listed for a state is 0 in that state.
//  Reset: state<=FETCH and wait counter<=0. mem_write, pc_write, reg_write and ir_write are also gated by !rst.
//    No write occurs in any cycle where rst is high, including reset mid-instruction.
//  FETCH: mem_req=1, adr_src=0, a=00, b=10, add, result_src=10.
//    ir_write=pc_write=mem_ready. Stay until mem_ready, then go to DECODE.
//  DECODE: a=01, b=01, add (branch/JAL target into ALUOut).
//    lw/sw->MEM_ADR. R->EXEC_R. I-ALU->EXEC_I. jal->JAL. branch->BRANCH. Any other opcode->TRAP.
//  ALU funct3 (R and I): 000 add (sub if R and funct_7_5), 010 slt, 110 or, 111 and; others->TRAP.
//  Branch funct3: 000 beq sub, taken=zero; 001 bne sub, taken=!zero; 100 blt slt, taken=!zero;
//    101 bge slt, taken=zero; others->TRAP (checked in DECODE).
//  MEM_ADR: a=10, b=01, add. Loads go to MEM_READ, stores to MEM_WRITE.
//  MEM_READ: mem_req=1, adr_src=1. Wait for mem_ready, then go to MEM_WB.
//  MEM_WRITE: mem_req=1, mem_write=1, adr_src=1. Wait for mem_ready, then go to FETCH.
//  MEM_WB: result_src=01, reg_write=1, then go to FETCH.
//  EXEC_R: a=10, b=00. EXEC_I: a=10, b=01. Both use decoded alu_ctrl and go to ALU_WB.
//  ALU_WB: result_src=00, reg_write=1, then go to FETCH.
//  JAL: a=01, b=10, add, result_src=00, pc_write=1, then go to ALU_WB (rd<=OldPC+4).
//  BRANCH: a=10, b=00, alu per funct3, result_src=00, pc_write=taken, then go to FETCH.
//  Latency in cycles (zero-wait memory): lw 5, sw 4, R/I 4, jal 4, branch 3.
//    Each wait cycle in FETCH, MEM_READ or MEM_WRITE adds 1.
//  Wait counter, 8 bits, saturating: cleared on entry to a wait state and on mem_ready; increments while
//    mem_req && !mem_ready. Counter==MEM_TIMEOUT with !mem_ready (MEM_TIMEOUT!=0) -> TRAP next cycle.
//  TRAP: mem_req=0, all writes 0, trap=1. Left only by rst.
//  mem_ready is ignored when mem_req=0.
// TESTING
//  add (0x33, f3=0, f7_5=0), mem_ready=1: states 0,1,6,8,0; alu_ctrl=000 in EXEC_R; reg_write=1 only in ALU_WB.
//  lw (0x03), mem_ready low 3 cycles in MEM_READ: MEM_READ held 4 cycles; reg_write=1 one cycle in MEM_WB.
//  bne, zero=1 -> pc_write=0 in BRANCH; bne, zero=0 -> pc_write=1. bge with slt: taken iff zero=1.
//  jal (0x6F): JAL gives pc_write=1 and result_src=00; ALU_WB follows with reg_write=1; imm_src=11 throughout.
//  MEM_TIMEOUT=4 with mem_ready stuck 0 in FETCH: TRAP entered after 5 wait cycles; trap=1 until rst.
//  Opcode 0x7F -> TRAP after DECODE. rst asserted in MEM_WRITE: mem_write=0 that cycle; state=0 next.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Control sequencer for a multi-cycle RV32I datapath sharing one instruction/data memory port.
// Moore state outputs, memory ready handshake with a wait-cycle timeout, and a sticky trap state.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct_3,
  input  logic       funct_7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_ctrl,
  output logic [1:0] imm_src,
  output logic       trap,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADR   = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_JAL       = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_TRAP      = 4'd15;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  logic [3:0] state_q, next_state;
  logic [7:0] wait_cnt;
  logic       timeout;
  logic       alu_legal, br_legal, taken;
  logic [2:0] alu_dec, br_alu;
  logic       mem_write_raw, ir_write_raw, pc_write_raw, reg_write_raw;

  assign state = state_q;

  // ALU and branch function decode from funct fields; illegal encodings steer DECODE to TRAP
  always_comb begin
    alu_legal = 1'b1;
    alu_dec   = 3'b000;
    case (funct_3)
      3'b000:  alu_dec = (opcode == OP_R && funct_7_5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_legal = 1'b0;
    endcase
    br_legal = 1'b1;
    br_alu   = 3'b001;
    taken    = 1'b0;
    case (funct_3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  begin br_alu = 3'b101; taken = !zero; end
      3'b101:  begin br_alu = 3'b101; taken = zero; end
      default: br_legal = 1'b0;
    endcase
    case (opcode)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  assign timeout = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && (wait_cnt == TIMEOUT_CNT);

  always_comb begin
    next_state = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) next_state = S_DECODE;
                   else if (timeout) next_state = S_TRAP;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
          OP_R:      next_state = alu_legal ? S_EXEC_R : S_TRAP;
          OP_I:      next_state = alu_legal ? S_EXEC_I : S_TRAP;
          OP_JAL:    next_state = S_JAL;
          OP_BRANCH: next_state = br_legal ? S_BRANCH : S_TRAP;
          default:   next_state = S_TRAP;
        endcase
      end
      S_MEM_ADR:   next_state = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
                   else if (timeout) next_state = S_TRAP;
      S_MEM_WRITE: if (mem_ready) next_state = S_FETCH;
                   else if (timeout) next_state = S_TRAP;
      S_MEM_WB, S_ALU_WB, S_BRANCH: next_state = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL:    next_state = S_ALU_WB;
      default:     next_state = S_TRAP;
    endcase
  end

  // Wait counter only runs while a request is outstanding, so it restarts at zero on every new access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state_q <= next_state;
      if (!mem_req || mem_ready || next_state != state_q)
        wait_cnt <= 8'd0;
      else if (wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_write_raw = 1'b0;
    adr_src       = 1'b0;
    ir_write_raw  = 1'b0;
    pc_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    alu_ctrl      = 3'b000;
    trap          = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE:    begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      S_MEM_ADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_MEM_READ:  begin mem_req = 1'b1; adr_src = 1'b1; end
      S_MEM_WRITE: begin mem_req = 1'b1; adr_src = 1'b1; mem_write_raw = 1'b1; end
      S_MEM_WB:    begin result_src = 2'b01; reg_write_raw = 1'b1; end
      S_EXEC_R:    begin alu_src_a = 2'b10; alu_ctrl = alu_dec; end
      S_EXEC_I:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_ctrl = alu_dec; end
      S_ALU_WB:    reg_write_raw = 1'b1;
      S_JAL:       begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write_raw = 1'b1; end
      S_BRANCH:    begin alu_src_a = 2'b10; alu_ctrl = br_alu; pc_write_raw = taken; end
      S_TRAP:      trap = 1'b1;
      default:     trap = 1'b0;
    endcase
  end

  // Architectural writes are suppressed in any reset cycle, even mid-instruction
  assign mem_write = mem_write_raw & ~rst;
  assign ir_write  = ir_write_raw  & ~rst;
  assign pc_write  = pc_write_raw  & ~rst;
  assign reg_write = reg_write_raw & ~rst;

endmodule
